pc_update_unit: RTL and testbench
=================================

PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h8000_0180, exception redirect address (used only with PC_UPD_EXC_EN).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Adder2Out  input  32  branch target (PC+4 + shifted offset) from the branch-target adder.
REQ-006 BranchTaken  input  1  branch condition met this cycle.
REQ-007 Jump  input  1  J-type jump.
REQ-008 JumpIndex  input  26  instruction index field for J-type.
REQ-009 JumpReg  input  1  register jump (jr).
REQ-010 RegTarget  input  32  register-sourced target.
REQ-011 Stall  input  1  hold PC; fetch not accepted this cycle.
REQ-012 PCOut  output  32  current PC.
REQ-013 Adder1Out  output  32  PCOut + 4, feeds the branch-target adder.
REQ-014 FetchValid  output  1  PCOut is a valid fetch address this cycle.
REQ-015 RedirectPending  output  1  a redirect is buffered behind a stall.
REQ-016 ExcReq input 1 and EPCOut output 32 exist only with PC_UPD_EXC_EN.

Function
REQ-017 Adder1Out SHALL be combinational PCOut + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 Redirect target priority: JumpReg > Jump > BranchTaken > sequential (Adder1Out).
REQ-019 Jump target = {Adder1Out[31:28], JumpIndex, 2'b00}.
REQ-020 RegTarget and Adder2Out SHALL have bits [1:0] forced to 00 before loading.
REQ-021 FSM states: HOLD, RUN, STALLED; encoding 2 bits.
REQ-022 HOLD: entered on reset; FetchValid=0; PC unchanged; next cycle -> RUN.
REQ-023 RUN, Stall=0: PCOut <= selected target; FetchValid=1; stay RUN.
REQ-024 RUN, Stall=1: PCOut holds; -> STALLED; any redirect this cycle captured into the pending buffer, RedirectPending=1 from next cycle.
REQ-025 STALLED, Stall=1: PCOut holds; FetchValid=0; a new redirect overwrites the pending target (last wins).
REQ-026 STALLED, Stall=0: if a redirect is present this cycle it wins over the buffer; else if pending, PCOut <= pending target; else PCOut <= Adder1Out; buffer cleared; -> RUN.
REQ-027 FetchValid = (state==RUN) && !Stall, combinational.
REQ-028 Latency: redirect asserted in cycle N with no stall appears on PCOut in cycle N+1.

Reset
REQ-029 On Reset=1 at a clock edge: PCOut=RESET_PC, state=HOLD, pending buffer and RedirectPending=0, EPCOut=0; FetchValid=0.
REQ-030 Reset asserted mid-stall or with pending redirect SHALL discard the buffered redirect.
REQ-031 Reset overrides all other inputs including ExcReq.

Configuration
REQ-032 Macro PC_UPD_EXC_EN: when defined, ExcReq/EPCOut exist; ExcReq has highest non-reset priority, loads PCOut=EXC_VECTOR next cycle regardless of Stall, captures EPCOut<=PCOut, clears pending buffer, state -> RUN.
REQ-033 Without PC_UPD_EXC_EN: ports absent, no EPC register, behaviour as REQ-017..031.

Structure
REQ-034 Shared package holds FSM state typedef (HOLD/RUN/STALLED), PC width constant 32, and default RESET_PC/EXC_VECTOR constants.
REQ-035 One sub-module natural: pc_target_sel (combinational priority mux + jump-target formation); PC register, buffer and FSM in top.

Verification
REQ-036 Reset with RESET_PC=0 -> PCOut=0, FetchValid=0 one cycle, then PCOut 0,4,8,C on successive cycles; Adder1Out=PCOut+4.
REQ-037 PCOut=0x40, BranchTaken=1, Adder2Out=0x103 -> next PCOut=0x100; JumpReg+Jump+Branch together, RegTarget=0x200 -> PCOut=0x200.
REQ-038 PCOut=0x3000_0010, Jump=1, JumpIndex=0x0000040 -> PCOut=0x3000_0100.
REQ-039 Stall 3 cycles with branch to 0x500 in first stall cycle -> PCOut held, RedirectPending=1, then PCOut=0x500 after release; redirect to 0x600 on release cycle -> 0x600.
REQ-040 PCOut=0xFFFF_FFFC sequential -> PCOut=0x0; Reset during pending redirect -> PCOut=RESET_PC, RedirectPending=0.
REQ-041 With PC_UPD_EXC_EN: PCOut=0x80, Stall=1, ExcReq=1 -> PCOut=0x8000_0180, EPCOut=0x80, RedirectPending=0.

Source files
------------

// File: rtl/pc_update_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_update_unit_pkg
// Shared definitions for the PC update unit: PC width, default reset PC and
// exception vector, FSM state type and a word-alignment helper.
// ----------------------------------------------------------------------------
package pc_update_unit_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEF_EXC_VECTOR = 32'h8000_0180;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        STALLED = 2'd2
    } pc_state_e;

    // Instruction addresses are word aligned; drop the low two bits.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_update_unit_target_sel.sv
// ----------------------------------------------------------------------------
// pc_target_sel
// Combinational next-PC selection. Priority: jump_reg > jump > branch_taken >
// sequential (pc_plus4). Also forms the J-type target from the PC+4 region.
//
// Ports:
//   pc_plus4      in  32  current PC + 4
//   branch_target in  32  branch-target adder output
//   branch_taken  in   1  branch condition met
//   jump          in   1  J-type jump
//   jump_index    in  26  J-type instruction index
//   jump_reg      in   1  register jump
//   reg_target    in  32  register-sourced target
//   next_target   out 32  selected next PC
//   redirect      out  1  a non-sequential target was selected
// ----------------------------------------------------------------------------
module pc_target_sel
    import pc_update_unit_pkg::*;
(
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [PC_W-1:0] branch_target,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic [25:0]     jump_index,
    input  logic            jump_reg,
    input  logic [PC_W-1:0] reg_target,
    output logic [PC_W-1:0] next_target,
    output logic            redirect
);

    always_comb begin
        next_target = pc_plus4;
        redirect    = 1'b0;
        if (jump_reg) begin
            next_target = word_align(reg_target);
            redirect    = 1'b1;
        end else if (jump) begin
            // J-type stays inside the 256 MB region of the delay-slot PC.
            next_target = {pc_plus4[PC_W-1:28], jump_index, 2'b00};
            redirect    = 1'b1;
        end else if (branch_taken) begin
            next_target = word_align(branch_target);
            redirect    = 1'b1;
        end
    end

endmodule

// File: rtl/pc_update_unit.sv
// ----------------------------------------------------------------------------
// pc_update_unit
// Program counter register with a HOLD/RUN/STALLED FSM. A redirect that
// arrives while fetch is stalled is parked in a one-entry buffer (last one
// wins) and applied on stall release unless a fresh redirect arrives then.
//
// Optional feature: define PC_UPD_EXC_EN to add ExcReq/EPCOut. An exception
// redirects to EXC_VECTOR next cycle regardless of Stall and saves the PC.
//
// Ports:
//   Clk             in   1  clock, rising edge
//   Reset           in   1  synchronous active-high reset
//   Adder2Out       in  32  branch target
//   BranchTaken     in   1  branch taken
//   Jump            in   1  J-type jump
//   JumpIndex       in  26  J-type index field
//   JumpReg         in   1  register jump
//   RegTarget       in  32  register target
//   Stall           in   1  hold PC, fetch not accepted
//   ExcReq          in   1  exception request (PC_UPD_EXC_EN only)
//   EPCOut          out 32  saved exception PC (PC_UPD_EXC_EN only)
//   PCOut           out 32  current PC
//   Adder1Out       out 32  PCOut + 4
//   FetchValid      out  1  PCOut is a valid fetch this cycle
//   RedirectPending out  1  a redirect is buffered behind a stall
// ----------------------------------------------------------------------------
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [PC_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [PC_W-1:0] Adder2Out,
    input  logic            BranchTaken,
    input  logic            Jump,
    input  logic [25:0]     JumpIndex,
    input  logic            JumpReg,
    input  logic [PC_W-1:0] RegTarget,
    input  logic            Stall,
`ifdef PC_UPD_EXC_EN
    input  logic            ExcReq,
    output logic [PC_W-1:0] EPCOut,
`endif
    output logic [PC_W-1:0] PCOut,
    output logic [PC_W-1:0] Adder1Out,
    output logic            FetchValid,
    output logic            RedirectPending
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] sel_target;
    logic            redirect;

`ifdef PC_UPD_EXC_EN
    logic [PC_W-1:0] epc_q, epc_d;
`else
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    pc_target_sel u_target_sel (
        .pc_plus4      (pc_plus4),
        .branch_target (Adder2Out),
        .branch_taken  (BranchTaken),
        .jump          (Jump),
        .jump_index    (JumpIndex),
        .jump_reg      (JumpReg),
        .reg_target    (RegTarget),
        .next_target   (sel_target),
        .redirect      (redirect)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        unique case (state_q)
            HOLD: state_d = RUN;
            RUN: begin
                if (!Stall) begin
                    pc_d = sel_target;
                end else begin
                    // Buffer is empty in RUN; capture this cycle's redirect, if any.
                    state_d = STALLED;
                    pend_d  = redirect;
                    if (redirect) pend_pc_d = sel_target;
                end
            end
            STALLED: begin
                if (Stall) begin
                    if (redirect) begin
                        pend_d    = 1'b1;
                        pend_pc_d = sel_target;
                    end
                end else begin
                    // A redirect on the release cycle is newer than the buffer.
                    if (redirect)    pc_d = sel_target;
                    else if (pend_q) pc_d = pend_pc_q;
                    else             pc_d = pc_plus4;
                    pend_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = HOLD;
        endcase
`ifdef PC_UPD_EXC_EN
        epc_d = epc_q;
        if (ExcReq) begin
            pc_d    = EXC_VECTOR;
            epc_d   = pc_q;
            pend_d  = 1'b0;
            state_d = RUN;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= HOLD;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
`ifdef PC_UPD_EXC_EN
            epc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
`ifdef PC_UPD_EXC_EN
            epc_q     <= epc_d;
`endif
        end
    end

    assign PCOut           = pc_q;
    assign Adder1Out       = pc_plus4;
    assign FetchValid      = (state_q == RUN) && !Stall;
    assign RedirectPending = pend_q;
`ifdef PC_UPD_EXC_EN
    assign EPCOut          = epc_q;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
module tb_pc_update_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Adder2Out;
    logic        BranchTaken;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic        Stall;
    logic [31:0] PCOut;
    logic [31:0] Adder1Out;
    logic        FetchValid;
    logic        RedirectPending;
`ifdef PC_UPD_EXC_EN
    logic        ExcReq;
    logic [31:0] EPCOut;
`endif

    pc_update_unit dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Adder2Out       (Adder2Out),
        .BranchTaken     (BranchTaken),
        .Jump            (Jump),
        .JumpIndex       (JumpIndex),
        .JumpReg         (JumpReg),
        .RegTarget       (RegTarget),
        .Stall           (Stall),
`ifdef PC_UPD_EXC_EN
        .ExcReq          (ExcReq),
        .EPCOut          (EPCOut),
`endif
        .PCOut           (PCOut),
        .Adder1Out       (Adder1Out),
        .FetchValid      (FetchValid),
        .RedirectPending (RedirectPending)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        st;
        logic        br;
        logic        j;
        logic        jr;
        logic [31:0] a2;
        logic [25:0] ji;
        logic [31:0] rt;
        logic        fv;   // FetchValid before the edge
        logic [31:0] pc;   // PCOut after the edge
        logic        rp;   // RedirectPending after the edge
    } vec_t;

    vec_t        tbl[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_pc;

    function automatic vec_t mk(logic st, logic br, logic j, logic jr,
                                logic [31:0] a2, logic [25:0] ji, logic [31:0] rt,
                                logic fv, logic [31:0] pc, logic rp);
        vec_t v;
        v.st = st; v.br = br; v.j = j; v.jr = jr; v.a2 = a2; v.ji = ji; v.rt = rt;
        v.fv = fv; v.pc = pc; v.rp = rp;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge Clk);
        Stall = v.st; BranchTaken = v.br; Jump = v.j; JumpReg = v.jr;
        Adder2Out = v.a2; JumpIndex = v.ji; RegTarget = v.rt;
        #1;
        chk("fetch_valid", idx, {31'd0, FetchValid}, {31'd0, v.fv});
        chk("adder1_out", idx, Adder1Out, cur_pc + 32'd4);
        @(posedge Clk);
        #1;
        chk("pc_out", idx, PCOut, v.pc);
        chk("redirect_pending", idx, {31'd0, RedirectPending}, {31'd0, v.rp});
        cur_pc = v.pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        Adder2Out = '0; JumpIndex = '0; RegTarget = '0;
`ifdef PC_UPD_EXC_EN
        ExcReq = 1'b0;
`endif
        //           st br j  jr a2             ji        rt             fv pc             rp
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0000, 0)); // HOLD
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         1, 32'h0000_0004, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         1, 32'h0000_0008, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         1, 32'h0000_000C, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,         26'h0,   32'h41,        1, 32'h0000_0040, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h103,       26'h0,   32'h0,         1, 32'h0000_0100, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h300,       26'h123, 32'h200,       1, 32'h0000_0200, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,         26'h0,   32'h3000_0010, 1, 32'h3000_0010, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,         26'h40,  32'h0,         1, 32'h3000_0100, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,         26'h0,   32'h400,       1, 32'h0000_0400, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h500,       26'h0,   32'h0,         0, 32'h0000_0400, 1)); // stall + branch
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0400, 1));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0400, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0500, 0)); // release
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         1, 32'h0000_0504, 0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h700,       26'h0,   32'h0,         0, 32'h0000_0504, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,         26'h0,   32'h600,       0, 32'h0000_0600, 0)); // release redirect wins
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0600, 0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,         26'h10,  32'h0,         0, 32'h0000_0600, 1));
        tbl.push_back(mk(1, 1, 0, 0, 32'h800,       26'h0,   32'h0,         0, 32'h0000_0600, 1)); // last wins
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0800, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0800, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 32'h0000_0804, 0)); // no pending
        tbl.push_back(mk(0, 0, 0, 1, 32'h0,         26'h0,   32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         1, 32'h0000_0000, 0)); // wrap

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_pc", -1, PCOut, 32'h0);
        chk("reset_rp", -1, {31'd0, RedirectPending}, 32'd0);
        chk("reset_fv", -1, {31'd0, FetchValid}, 32'd0);
`ifdef PC_UPD_EXC_EN
        chk("reset_epc", -1, EPCOut, 32'h0);
`endif
        Reset  = 1'b0;
        cur_pc = 32'h0;

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset while a redirect is buffered discards it.
        apply(mk(1, 1, 0, 0, 32'h900, 26'h0, 32'h0, 0, 32'h0, 1), 100);
        @(negedge Clk);
        Reset = 1'b1; Stall = 1'b1; BranchTaken = 1'b1; Adder2Out = 32'h904;
        @(posedge Clk);
        #1;
        chk("rst_pend_pc", 101, PCOut, 32'h0);
        chk("rst_pend_rp", 101, {31'd0, RedirectPending}, 32'd0);
        chk("rst_pend_fv", 101, {31'd0, FetchValid}, 32'd0);
        Reset  = 1'b0;
        cur_pc = 32'h0;
        apply(mk(0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 0, 32'h0, 0), 102);
        apply(mk(0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 1, 32'h4, 0), 103);

`ifdef PC_UPD_EXC_EN
        apply(mk(0, 0, 0, 1, 32'h0, 26'h0, 32'h80, 1, 32'h80, 0), 200);
        apply(mk(1, 1, 0, 0, 32'h900, 26'h0, 32'h0, 0, 32'h80, 1), 201);
        @(negedge Clk);
        Stall = 1'b1; ExcReq = 1'b1; BranchTaken = 1'b0;
        @(posedge Clk);
        #1;
        chk("exc_pc", 202, PCOut, 32'h8000_0180);
        chk("exc_epc", 202, EPCOut, 32'h80);
        chk("exc_rp", 202, {31'd0, RedirectPending}, 32'd0);
        ExcReq = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
